vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port vga_req, input, 1: one-cycle video fetch strobe, at most one per 16 cycles.
REQ-004 SHALL have port vga_addr, input, 13: video fetch address, valid while vga_req is high.
REQ-005 SHALL have port vga_data, output, 8: registered fetch result, held until the next fetch completes.
REQ-006 SHALL have port cpu_req, input, 1: CPU access request level, held until cpu_ready.
REQ-007 SHALL have port cpu_we, input, 1: 1 = write, 0 = read, valid with cpu_req.
REQ-008 SHALL have port cpu_addr, input, 13: CPU address, valid with cpu_req.
REQ-009 SHALL have port cpu_din, input, 8: CPU write data, valid with cpu_req.
REQ-010 SHALL have port cpu_dout, output, 8: registered CPU read data.
REQ-011 SHALL have port cpu_ready, output, 1: one-cycle completion pulse.
REQ-012 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, 13) and mem_wdata (output, 8): registered single-port RAM controls.
REQ-013 SHALL have port mem_rdata, input, 8: RAM read data, valid one cycle after the cycle in which mem_en is driven.

Function
REQ-014 SHALL decide one RAM access per cycle and drive it registered in the following cycle; priority: VGA first, CPU second.
REQ-015 SHALL, when vga_req is high in cycle T, drive a read of vga_addr in T+1, capture mem_rdata at the end of T+2 and present it on vga_data from T+3; this fixed latency of 3 SHALL hold regardless of CPU activity.
REQ-016 SHALL run a CPU FSM with states C_IDLE, C_RD, C_CAP, C_DONE; C_IDLE SHALL accept cpu_req only in a cycle with vga_req low.
REQ-017 SHALL handle an accepted CPU read in cycle A as follows: C_RD with the RAM read driven in A+1; C_CAP in A+2 with mem_rdata captured into cpu_dout; C_DONE in A+3 with cpu_ready=1; C_IDLE in A+4.
REQ-018 SHALL handle an accepted CPU write in cycle A as follows: mem_we=1 with the RAM write driven in A+1; C_DONE in A+2 with cpu_ready=1; C_IDLE in A+3.
REQ-019 SHALL ignore cpu_req during C_DONE, so a request held over the ready cycle is not re-accepted.
REQ-020 SHALL, when vga_req and cpu_req are high in the same cycle, issue the VGA access and defer CPU acceptance by exactly one cycle; the worst-case extra CPU latency SHALL be 1 cycle.
REQ-021 SHALL drive mem_en=0 and mem_we=0 in every cycle with no issued access; mem_addr and mem_wdata SHALL hold their last values.
REQ-022 SHALL leave vga_data unchanged while a CPU read completes, and leave cpu_dout unchanged while a VGA fetch or CPU write completes.
REQ-023 SHALL wrap no addresses: 13-bit addresses pass unmodified, covering 0x0000-0x1FFF.

Reset
REQ-024 SHALL, while reset is high, set the FSM to C_IDLE, vga_data=0, cpu_dout=0, cpu_ready=0, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-025 SHALL abandon any in-flight access on reset, with no cpu_ready pulse and no vga_data update for it; mem_en SHALL be 0 in the cycle after reset deasserts.

Configuration
REQ-026 SHALL, with macro VRAM_ARBITER_WRITE_BUFFER_EN defined, include a one-entry posted write buffer: in C_IDLE, a CPU write with the buffer empty SHALL be latched with cpu_ready=1 in the next cycle even if vga_req is high.
REQ-027 SHALL, with VRAM_ARBITER_WRITE_BUFFER_EN defined, drain the buffer in the first cycle with vga_req low and no CPU read being decided, and make any CPU read or second write wait in C_IDLE until the buffer is empty, so write-then-read ordering is preserved.
REQ-028 SHALL, with VRAM_ARBITER_WRITE_BUFFER_EN undefined, contain no buffer; writes behave per REQ-018 exactly.

Verification
REQ-029 SHALL cover this case: RAM[0x0123]=0x5A, vga_req pulse at cycle 10 with vga_addr=0x0123 -> mem_en=1 at cycle 11, vga_data=0x5A from cycle 13.
REQ-030 SHALL cover this case: CPU read of 0x1FFF (RAM=0xC3) accepted at cycle 20 -> cpu_ready=1 only at cycle 23 with cpu_dout=0xC3, and no re-acceptance at cycle 23 while cpu_req is held.
REQ-031 SHALL cover this case: vga_req and cpu_req (write 0x0040=0xAA) both high at cycle 30 -> VGA read at cycle 31, CPU write at cycle 32, cpu_ready at cycle 33, RAM[0x0040]=0xAA.
REQ-032 SHALL cover this case: vga_req every 16 cycles plus back-to-back CPU reads for 1000 cycles -> every vga_data lands exactly 3 cycles after its vga_req, and every CPU read completes within 4 cycles of its request.
REQ-033 SHALL cover this case: reset asserted in the C_CAP cycle of a CPU read -> no cpu_ready, cpu_dout=0, and mem_en=0 after reset deasserts.
REQ-034 SHALL cover this case with VRAM_ARBITER_WRITE_BUFFER_EN defined: CPU write 0x0100=0x11 coincident with vga_req, then an immediate read of 0x0100 -> write cpu_ready 1 cycle after acceptance, and the read returns 0x11.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: VGA fetch, CPU access and single-port RAM control signals of the arbiter.
// slave is the arbiter's view; master is the requester/RAM side.
interface vram_arbiter_if;
    logic        vga_req;
    logic [12:0] vga_addr;
    logic [7:0]  vga_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ready;
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_din, mem_rdata,
        output vga_data, cpu_dout, cpu_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_din, mem_rdata,
        input  vga_data, cpu_dout, cpu_ready, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter; VGA fetches win and have fixed latency 3, the CPU
// is served by a small FSM. Define VRAM_ARBITER_WRITE_BUFFER_EN for a one-entry posted write buffer.
module vram_arbiter (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RD   = 2'd1,
        C_CAP  = 2'd2,
        C_DONE = 2'd3
    } cpu_state_e;

    cpu_state_e  r_state, w_state_next;
    logic        r_cpu_we;
    logic        r_vga_p1, r_vga_p2;
    logic [7:0]  r_vga_data, r_cpu_dout;
    logic        r_mem_en, r_mem_we;
    logic [12:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;

    logic        w_cpu_accept;
    logic        w_mem_en, w_mem_we;
    logic [12:0] w_mem_addr;
    logic [7:0]  w_mem_wdata;

`ifdef VRAM_ARBITER_WRITE_BUFFER_EN
    logic        r_wb_valid;
    logic [12:0] r_wb_addr;
    logic [7:0]  r_wb_data;
    logic        w_wb_latch, w_wb_drain;

    // Writes are posted into the buffer; only reads take the FSM access path.
    assign w_wb_latch   = (r_state == C_IDLE) && bus.cpu_req && bus.cpu_we && !r_wb_valid;
    assign w_cpu_accept = (r_state == C_IDLE) && bus.cpu_req && !bus.cpu_we && !r_wb_valid &&
                          !bus.vga_req;
    assign w_wb_drain   = r_wb_valid && !bus.vga_req && !w_cpu_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else if (w_wb_latch) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= bus.cpu_addr;
            r_wb_data  <= bus.cpu_din;
        end else if (w_wb_drain) begin
            r_wb_valid <= 1'b0;
        end
    end
`else
    assign w_cpu_accept = (r_state == C_IDLE) && bus.cpu_req && !bus.vga_req;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_cpu_accept) begin
                    w_state_next = C_RD;
`ifdef VRAM_ARBITER_WRITE_BUFFER_EN
                end else if (w_wb_latch) begin
                    w_state_next = C_DONE;
`endif
                end
            end
            // C_RD also carries the write access cycle of an unbuffered write.
            C_RD:    w_state_next = r_cpu_we ? C_DONE : C_CAP;
            C_CAP:   w_state_next = C_DONE;
            C_DONE:  w_state_next = C_IDLE;
            default: w_state_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= C_IDLE;
            r_cpu_we <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_cpu_accept) begin
                r_cpu_we <= bus.cpu_we;
            end
        end
    end

    // One access decided per cycle, VGA first; issued on the registered RAM controls next cycle.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        if (bus.vga_req) begin
            w_mem_en   = 1'b1;
            w_mem_addr = bus.vga_addr;
        end else if (w_cpu_accept) begin
            w_mem_en   = 1'b1;
            w_mem_we   = bus.cpu_we;
            w_mem_addr = bus.cpu_addr;
            if (bus.cpu_we) begin
                w_mem_wdata = bus.cpu_din;
            end
`ifdef VRAM_ARBITER_WRITE_BUFFER_EN
        end else if (w_wb_drain) begin
            w_mem_en    = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = r_wb_addr;
            w_mem_wdata = r_wb_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_vga_p1    <= 1'b0;
            r_vga_p2    <= 1'b0;
            r_vga_data  <= '0;
            r_cpu_dout  <= '0;
        end else begin
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_vga_p1    <= bus.vga_req;
            r_vga_p2    <= r_vga_p1;
            if (r_vga_p2) begin
                r_vga_data <= bus.mem_rdata;
            end
            if (r_state == C_CAP) begin
                r_cpu_dout <= bus.mem_rdata;
            end
        end
    end

    assign bus.vga_data  = r_vga_data;
    assign bus.cpu_dout  = r_cpu_dout;
    assign bus.cpu_ready = (r_state == C_DONE);
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule
